// File: rtl/bsg_down_rx_pkg.sv
// Shared defaults and width derivations for the down-link receive buffer.
package bsg_down_rx_pkg;

    localparam int unsigned IO_W_DEF      = 8;
    localparam int unsigned PACK_DEF      = 2;
    localparam int unsigned DEPTH_DEF     = 64;
    localparam int unsigned CORE_PACK_DEF = 2;
    localparam int unsigned TOKEN_DEC_DEF = 4;

    // Address width into the word storage.
    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Pointers carry one extra wrap bit to tell full from empty.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Gather beat counter width; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned pack);
        return (pack <= 1) ? 1 : $clog2(pack);
    endfunction

    // Token accumulator must hold up to 2*TOKEN_DEC-1 before wrapping back.
    function automatic int unsigned tok_w(input int unsigned token_dec);
        return $clog2(token_dec) + 1;
    endfunction

endpackage

// File: rtl/bsg_down_rx_gather.sv
// Packs PACK io beats into one buffer word, first beat in the lowest bits.
module bsg_down_rx_gather
    import bsg_down_rx_pkg::*;
#(
    parameter int unsigned IO_W = IO_W_DEF,
    parameter int unsigned PACK = PACK_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 io_valid_in,
    input  logic [IO_W-1:0]      io_data_in,
    output logic [IO_W*PACK-1:0] word,
    output logic                 word_valid
);

    localparam int unsigned CW     = cnt_w(PACK);
    localparam int unsigned WORD_W = IO_W * PACK;

    logic [CW-1:0]     beat_cnt;
    logic [WORD_W-1:0] partial;
    logic              last_beat;

    assign last_beat  = (beat_cnt == CW'(PACK - 1));
    assign word_valid = io_valid_in && last_beat && !rst;

    // The completed word includes the beat arriving this cycle.
    always_comb begin
        word = partial;
        for (int unsigned k = 0; k < PACK; k++) begin
            if (beat_cnt == CW'(k)) begin
                word[k*IO_W +: IO_W] = io_data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            partial  <= '0;
        end else if (io_valid_in) begin
            if (last_beat) begin
                beat_cnt <= '0;
                partial  <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                partial  <= word;
            end
        end
    end

endmodule

// File: rtl/bsg_down_rx_buffer.sv
// Down-link receive buffer: gathers io beats into words, queues them, hands
// CORE_PACK words per core beat and returns credit tokens as space frees up.
module bsg_down_rx_buffer
    import bsg_down_rx_pkg::*;
#(
    parameter int unsigned IO_W      = IO_W_DEF,
    parameter int unsigned PACK      = PACK_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned CORE_PACK = CORE_PACK_DEF,
    parameter int unsigned TOKEN_DEC = TOKEN_DEC_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           io_valid_in,
    input  logic [IO_W-1:0]                io_data_in,
    input  logic                           core_ready,
    input  logic                           overflow_clr,
    output logic                           core_valid_out,
    output logic [IO_W*PACK*CORE_PACK-1:0] core_data_out,
    output logic                           io_token_out,
    output logic                           full,
    output logic                           empty,
    output logic [ptr_w(DEPTH)-1:0]        count,
    output logic                           overflow
);

    localparam int unsigned WORD_W = IO_W * PACK;
    localparam int unsigned AW     = addr_w(DEPTH);
    localparam int unsigned TW     = tok_w(TOKEN_DEC);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              wr_en;
    logic              drop;
    logic              deq;
    logic [TW-1:0]     tok_cnt;
    logic [TW-1:0]     tok_sum;
    logic              tok_hit;

    bsg_down_rx_gather #(
        .IO_W (IO_W),
        .PACK (PACK)
    ) gather (
        .clk         (clk),
        .rst         (rst),
        .io_valid_in (io_valid_in),
        .io_data_in  (io_data_in),
        .word        (word),
        .word_valid  (word_valid)
    );

    // Status comes from start-of-cycle pointers, so a dequeue never rescues
    // a word that arrives while full.
    assign count          = wptr - rptr;
    assign empty          = (wptr == rptr);
    assign full           = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign core_valid_out = (count >= (AW+1)'(CORE_PACK));

    assign wr_en = word_valid && !full;
    assign drop  = word_valid && full;
    assign deq   = core_valid_out && core_ready;

    assign tok_sum = tok_cnt + TW'(CORE_PACK);
    assign tok_hit = (tok_sum >= TW'(TOKEN_DEC));

    always_comb begin
        core_data_out = '0;
        if (core_valid_out) begin
            for (int unsigned i = 0; i < CORE_PACK; i++) begin
                core_data_out[i*WORD_W +: WORD_W] = mem[rptr[AW-1:0] + AW'(i)];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (deq) begin
                rptr <= rptr + (AW+1)'(CORE_PACK);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tok_cnt      <= '0;
            io_token_out <= 1'b0;
        end else begin
            io_token_out <= deq && tok_hit;
            if (deq) begin
                tok_cnt <= tok_hit ? (tok_sum - TW'(TOKEN_DEC)) : tok_sum;
            end
        end
    end

endmodule

// File: tb/tb_bsg_down_rx_buffer.sv
// Self-checking bench: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bsg_down_rx_buffer;

    localparam int IO_W   = 8;
    localparam int PACK   = 2;
    localparam int DEPTH  = 64;
    localparam int CP     = 2;
    localparam int TD     = 4;
    localparam int WW     = IO_W * PACK;
    localparam int CW     = WW * CP;

    logic          clk = 1'b0;
    logic          rst;
    logic          io_valid_in;
    logic [IO_W-1:0] io_data_in;
    logic          core_ready;
    logic          overflow_clr;
    logic          core_valid_out;
    logic [CW-1:0] core_data_out;
    logic          io_token_out;
    logic          full;
    logic          empty;
    logic [6:0]    count;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    bsg_down_rx_buffer #(
        .IO_W      (IO_W),
        .PACK      (PACK),
        .DEPTH     (DEPTH),
        .CORE_PACK (CP),
        .TOKEN_DEC (TD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .io_valid_in    (io_valid_in),
        .io_data_in     (io_data_in),
        .core_ready     (core_ready),
        .overflow_clr   (overflow_clr),
        .core_valid_out (core_valid_out),
        .core_data_out  (core_data_out),
        .io_token_out   (io_token_out),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the buffer is a queue of words, tokens are
    // floor(total words freed / TD) with a one-cycle delay.
    logic [WW-1:0] m_q[$];
    logic [WW-1:0] m_part;
    logic [WW-1:0] m_word;
    int            m_beats;
    int            m_freed;
    int            m_n0;
    bit            m_ovf;
    bit            m_tok;
    bit            m_live = 0;
    bit            m_done;
    bit            m_full0;
    bit            m_deq;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_part  = '0;
            m_beats = 0;
            m_ovf   = 0;
            m_tok   = 0;
            m_freed = 0;
            m_live  = 1;
        end else if (m_live) begin
            m_n0    = m_q.size();
            m_full0 = (m_n0 == DEPTH);
            m_deq   = (m_n0 >= CP) && (core_ready === 1'b1);
            m_done  = 0;
            if (io_valid_in === 1'b1) begin
                m_part[m_beats*IO_W +: IO_W] = io_data_in;
                m_beats++;
                if (m_beats == PACK) begin
                    m_word  = m_part;
                    m_done  = 1;
                    m_part  = '0;
                    m_beats = 0;
                end
            end
            if (overflow_clr === 1'b1) m_ovf = 0;
            if (m_done && m_full0) m_ovf = 1;
            m_tok = m_deq && (((m_freed + CP) / TD) > (m_freed / TD));
            if (m_deq) begin
                repeat (CP) void'(m_q.pop_front());
                m_freed += CP;
            end
            if (m_done && !m_full0) m_q.push_back(m_word);
        end
    end

    logic [CW-1:0] e_data;
    int            tok_seen = 0;

    always @(negedge clk) begin
        if (rst === 1'b1) tok_seen = 0;
        else if (io_token_out === 1'b1) tok_seen++;
        if (m_live) begin
            e_data = '0;
            if (m_q.size() >= CP) begin
                for (int i = 0; i < CP; i++) e_data[i*WW +: WW] = m_q[i];
            end
            chk("m_count", 64'(count), 64'(m_q.size()));
            chk("m_empty", 64'(empty), 64'(m_q.size() == 0));
            chk("m_full", 64'(full), 64'(m_q.size() == DEPTH));
            chk("m_valid", 64'(core_valid_out), 64'(m_q.size() >= CP));
            chk("m_data", 64'(core_data_out), 64'(e_data));
            chk("m_token", 64'(io_token_out), 64'(m_tok));
            chk("m_overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [IO_W-1:0] d);
        io_valid_in = 1'b1;
        io_data_in  = d;
        step();
        io_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        io_valid_in  = 1'b0;
        io_data_in   = '0;
        core_ready   = 1'b0;
        overflow_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_valid", 64'(core_valid_out), 64'd0);
        chk("rst_data", 64'(core_data_out), 64'd0);
        chk("rst_token", 64'(io_token_out), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // Four beats -> two words, one core beat.
        beat(8'h11);
        beat(8'h22);
        beat(8'h33);
        chk("gather_partial_count", 64'(count), 64'd1);
        beat(8'h44);
        chk("gather_count", 64'(count), 64'd2);
        chk("gather_valid", 64'(core_valid_out), 64'd1);
        chk("gather_data", 64'(core_data_out), 64'h44332211);
        core_ready = 1'b1;
        step();
        core_ready = 1'b0;
        chk("drain_count", 64'(count), 64'd0);

        // Fill to full, overflow, clear.
        do_reset();
        for (int i = 0; i < 128; i++) beat(8'(i));
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd64);
        chk("fill_data", 64'(core_data_out), 64'h03020100);
        beat(8'hE0);
        beat(8'hE1);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd64);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("ovf_clear", 64'(overflow), 64'd0);

        // Two dequeues from full -> one token right after the second.
        core_ready = 1'b1;
        step();
        chk("tok_first", 64'(io_token_out), 64'd0);
        step();
        core_ready = 1'b0;
        chk("tok_count60", 64'(count), 64'd60);
        chk("tok_pulse", 64'(io_token_out), 64'd1);
        step();
        chk("tok_single", 64'(io_token_out), 64'd0);

        // Refill, then last beat lands with a dequeue while full.
        for (int i = 0; i < 8; i++) beat(8'hB0 + 8'(i));
        chk("refill_full", 64'(full), 64'd1);
        beat(8'hC0);
        core_ready = 1'b1;
        beat(8'hC1);
        core_ready = 1'b0;
        chk("coinc_count", 64'(count), 64'd62);
        chk("coinc_overflow", 64'(overflow), 64'd1);

        // Reset mid-gather discards the partial word.
        do_reset();
        beat(8'hAA);
        rst         = 1'b1;
        io_valid_in = 1'b1;
        io_data_in  = 8'h55;
        step();
        rst         = 1'b0;
        io_valid_in = 1'b0;
        beat(8'h01);
        beat(8'h02);
        beat(8'h03);
        beat(8'h04);
        chk("rstmid_data", 64'(core_data_out), 64'h04030201);
        chk("rstmid_count", 64'(count), 64'd2);

        // Streaming with random back-pressure across pointer wrap.
        do_reset();
        for (int w = 0; w < 400; w++) begin
            for (int b = 0; b < PACK; b++) begin
                io_valid_in = 1'b1;
                io_data_in  = 8'($urandom);
                core_ready  = 1'($urandom_range(0, 1));
                step();
            end
        end
        io_valid_in = 1'b0;
        core_ready  = 1'b1;
        repeat (40) step();
        core_ready = 1'b0;
        step();
        step();
        chk("stream_drained", 64'(count), 64'd0);
        chk("stream_freed_min", 64'(m_freed >= 400), 64'd1);
        chk("stream_tokens", 64'(tok_seen), 64'(m_freed / TD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
